// File: rtl/noc_arb_pkg.sv
// Shared constants for the NoC round-robin output arbiter.
//   NUM_PORTS_DEF : default number of requesting input ports
//   HOLD_MAX_DEF  : default cap on consecutive grants to one owner (0 = no cap)
//   HOLD_CNT_W    : width of the per-owner grant counter (debug output)
//   HOLD_CNT_MAX  : saturation value of that counter
package noc_arb_pkg;

  localparam int unsigned NUM_PORTS_DEF = 5;
  localparam int unsigned HOLD_MAX_DEF  = 8;
  localparam int unsigned HOLD_CNT_W    = 8;

  localparam logic [HOLD_CNT_W-1:0] HOLD_CNT_MAX = '1;

endpackage

// File: rtl/rr_pick.sv
// Rotating first-set search.
// Finds the first set bit of req_i, starting at ptr_i+1 and wrapping modulo N.
// Bit ptr_i itself is examined last.
//   req_i   : request vector, bit i = port i
//   ptr_i   : index of the most recent owner (must be < N)
//   pick_o  : one-hot winner, all-zero when nothing is requested
//   valid_o : at least one request is set
module rr_pick #(
  parameter int N  = 5,
  parameter int PW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  pick_o,
  output logic          valid_o
);

  int best_rank;
  int best_idx;
  int rank;

  // Each port gets a rank equal to its distance after ptr_i:
  // ptr_i+1 -> 0 ... ptr_i -> N-1. The lowest ranked requester wins.
  // Ranks are unique, so the result is one-hot by construction.
  always_comb begin
    best_rank = N;
    best_idx  = 0;
    rank      = 0;
    valid_o   = 1'b0;
    for (int i = 0; i < N; i++) begin
      rank = (i + N - 1 - int'(ptr_i)) % N;
      if (req_i[i] && (rank < best_rank)) begin
        best_rank = rank;
        best_idx  = i;
        valid_o   = 1'b1;
      end
    end
    pick_o = '0;
    for (int i = 0; i < N; i++) begin
      pick_o[i] = valid_o && (best_idx == i);
    end
  end

endmodule

// File: rtl/noc_rr_arbiter.sv
// NoC output-port round-robin arbiter with a downstream rts/dcts handshake.
// One input port owns the output at a time. The owner keeps the output while it
// keeps requesting, up to HOLD_MAX grants (0 = no limit). After that, ownership
// rotates to the next requester after the last owner.
//
// Handshake: rts is registered. A grant happens in any cycle where rts and dcts
// are both high. While rts is high and dcts is low, the transfer is pending.
// During that time owner, ptr and hold_cnt are frozen, and every req change is
// ignored. rts drops for one cycle after each handshake, so grants are at
// least 2 cycles apart.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   req      : per-port request, bit i = port i
//   dcts     : downstream clear-to-send
//   grant    : per-port grant pulse (owner & rts & dcts), at most one bit set
//   xbar_sel : one-hot crossbar select = current owner, zero when idle
//   rts      : registered request-to-send to downstream
//   hold_cnt : grants issued to the current owner since it took ownership
module noc_rr_arbiter
  import noc_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = NUM_PORTS_DEF,
  parameter int unsigned HOLD_MAX  = HOLD_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_PORTS-1:0]  req,
  input  logic                  dcts,
  output logic [NUM_PORTS-1:0]  grant,
  output logic [NUM_PORTS-1:0]  xbar_sel,
  output logic                  rts,
  output logic [HOLD_CNT_W-1:0] hold_cnt
);

  localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_PORTS - 1);
  localparam bit HOLD_UNLIMITED = (HOLD_MAX == 0);
  localparam logic [HOLD_CNT_W:0] HOLD_LIMIT = (HOLD_CNT_W + 1)'(HOLD_MAX);

  logic [NUM_PORTS-1:0]  owner_q, owner_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  rts_q, rts_d;
  logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic                  handshake;
  logic                  pending;
  logic                  owner_idle;
  logic                  any_grant;
  logic [HOLD_CNT_W:0]   done;
  logic                  keep;
  logic [NUM_PORTS-1:0]  pick;
  logic                  pick_valid;
  logic [NUM_PORTS-1:0]  next_owner;
  logic [PTR_W-1:0]      next_idx;

  rr_pick #(
    .N  (NUM_PORTS),
    .PW (PTR_W)
  ) u_rr_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .pick_o  (pick),
    .valid_o (pick_valid)
  );

  assign handshake  = rts_q & dcts;
  assign pending    = rts_q & ~dcts;
  assign owner_idle = ~|owner_q;
  assign any_grant  = handshake & ~owner_idle;

  // Grants already issued to the owner, counting one from this cycle.
  // The counter is one bit wider, so a saturated hold_cnt cannot wrap.
  assign done = {1'b0, hold_cnt_q} + (HOLD_CNT_W + 1)'(any_grant);
  assign keep = (|(req & owner_q)) && (HOLD_UNLIMITED || (done < HOLD_LIMIT));

  // pick is all-zero when nothing is requested, which gives IDLE directly.
  assign next_owner = keep ? owner_q : pick;

  always_comb begin
    next_idx = ptr_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (next_owner[i]) next_idx = PTR_W'(i);
    end
  end

  always_comb begin
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    rts_d      = ~owner_idle & ~handshake;
    if (!pending) begin
      owner_d = next_owner;
      if (|next_owner) ptr_d = next_idx;
      if (keep) begin
        if (any_grant && (hold_cnt_q != HOLD_CNT_MAX)) begin
          hold_cnt_d = hold_cnt_q + HOLD_CNT_W'(1);
        end
      end else begin
        // A new owner, or re-selection of the same port after its hold
        // limit, starts a fresh count.
        hold_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= '0;
      ptr_q      <= PTR_RST;
      rts_q      <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      rts_q      <= rts_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign xbar_sel = owner_q;
  assign grant    = owner_q & {NUM_PORTS{handshake}};
  assign rts      = rts_q;
  assign hold_cnt = hold_cnt_q;

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Bench for noc_rr_arbiter.
// Two instances run side by side on shared inputs:
//   dut_a : NUM_PORTS=5, HOLD_MAX=2
//   dut_b : NUM_PORTS=5, HOLD_MAX=0
// Each has its own index-based reference model.
module tb_noc_rr_arbiter;

  localparam int NP = 5;

  logic          clk;
  logic          rst;
  logic [NP-1:0] req;
  logic          dcts;
  logic [NP-1:0] grant_a, xbar_a, grant_b, xbar_b;
  logic          rts_a, rts_b;
  logic [7:0]    hc_a, hc_b;

  noc_rr_arbiter #(.NUM_PORTS(NP), .HOLD_MAX(2)) dut_a (
    .clk(clk), .rst(rst), .req(req), .dcts(dcts),
    .grant(grant_a), .xbar_sel(xbar_a), .rts(rts_a), .hold_cnt(hc_a)
  );

  noc_rr_arbiter #(.NUM_PORTS(NP), .HOLD_MAX(0)) dut_b (
    .clk(clk), .rst(rst), .req(req), .dcts(dcts),
    .grant(grant_b), .xbar_sel(xbar_b), .rts(rts_b), .hold_cnt(hc_b)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks;
  int n_fail;

  // Reference model state. Owner is a port index, with -1 meaning idle.
  int  m_owner[2];
  int  m_ptr[2];
  int  m_hc[2];
  bit  m_rts[2];
  int  hmax[2];
  bit  model_valid;

  logic [NP-1:0] obs_grant[2];
  logic [NP-1:0] obs_xbar[2];
  logic          obs_rts[2];
  logic [7:0]    obs_hc[2];

  logic [NP-1:0] exp_q[$];

  function automatic bit bit_of(input logic [NP-1:0] v, input int i);
    return |(v & (NP'(1) << i));
  endfunction

  function automatic int oh_idx(input logic [NP-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NP; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Drive one cycle of inputs.
  // At mid-cycle, sample both DUTs, compare them against the model, then advance the model.
  task automatic step(input logic r, input logic [NP-1:0] rq, input logic d);
    logic [NP-1:0] exp_x, exp_g;
    int done, nxt, idx;
    bit g, new_rts;
    rst = r; req = rq; dcts = d;
    #4;
    obs_grant[0] = grant_a; obs_xbar[0] = xbar_a; obs_rts[0] = rts_a; obs_hc[0] = hc_a;
    obs_grant[1] = grant_b; obs_xbar[1] = xbar_b; obs_rts[1] = rts_b; obs_hc[1] = hc_b;
    for (int k = 0; k < 2; k++) begin
      exp_x = (m_owner[k] < 0) ? '0 : (NP'(1) << m_owner[k]);
      exp_g = (m_rts[k] && d) ? exp_x : '0;
      if (model_valid) begin
        n_checks++;
        if (obs_grant[k] !== exp_g) begin
          n_fail++;
          $display("FAIL model_grant dut%0d t=%0t got=%b exp=%b", k, $time, obs_grant[k], exp_g);
        end
        n_checks++;
        if (obs_xbar[k] !== exp_x) begin
          n_fail++;
          $display("FAIL model_xbar dut%0d t=%0t got=%b exp=%b", k, $time, obs_xbar[k], exp_x);
        end
        n_checks++;
        if (obs_rts[k] !== m_rts[k]) begin
          n_fail++;
          $display("FAIL model_rts dut%0d t=%0t got=%b exp=%b", k, $time, obs_rts[k], m_rts[k]);
        end
        n_checks++;
        if (obs_hc[k] !== 8'(m_hc[k])) begin
          n_fail++;
          $display("FAIL model_hold_cnt dut%0d t=%0t got=%0d exp=%0d", k, $time, obs_hc[k], m_hc[k]);
        end
      end
      if (r) begin
        m_owner[k] = -1; m_ptr[k] = NP - 1; m_rts[k] = 1'b0; m_hc[k] = 0;
      end else begin
        g       = (m_owner[k] >= 0) && m_rts[k] && d;
        new_rts = (m_owner[k] >= 0) && !(m_rts[k] && d);
        if (!(m_rts[k] && !d)) begin
          done = m_hc[k] + (g ? 1 : 0);
          if ((m_owner[k] >= 0) && bit_of(rq, m_owner[k]) && (hmax[k] == 0 || done < hmax[k])) begin
            m_hc[k] = (done > 255) ? 255 : done;
          end else begin
            nxt = -1;
            for (int j = 1; j <= NP; j++) begin
              idx = (m_ptr[k] + j) % NP;
              if (nxt < 0 && bit_of(rq, idx)) nxt = idx;
            end
            m_owner[k] = nxt;
            if (nxt >= 0) m_ptr[k] = nxt;
            m_hc[k] = 0;
          end
        end
        m_rts[k] = new_rts;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, NP'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    step(1'b1, NP'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_reset();
    do_reset();
    step(1'b0, '0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_grant[k] !== '0) begin n_fail++; $display("FAIL reset_grant dut%0d got=%b exp=0", k, obs_grant[k]); end
      n_checks++;
      if (obs_xbar[k] !== '0) begin n_fail++; $display("FAIL reset_xbar dut%0d got=%b exp=0", k, obs_xbar[k]); end
      n_checks++;
      if (obs_rts[k] !== 1'b0) begin n_fail++; $display("FAIL reset_rts dut%0d got=%b exp=0", k, obs_rts[k]); end
      n_checks++;
      if (obs_hc[k] !== 8'd0) begin n_fail++; $display("FAIL reset_hold_cnt dut%0d got=%0d exp=0", k, obs_hc[k]); end
    end
  endtask

  task automatic test_single_grant();
    do_reset();
    step(1'b0, 5'b00100, 1'b1);
    n_checks++;
    if (obs_xbar[0] !== 5'b00000) begin n_fail++; $display("FAIL single_c0_xbar got=%b exp=00000", obs_xbar[0]); end
    step(1'b0, 5'b00100, 1'b1);
    n_checks++;
    if (obs_xbar[0] !== 5'b00100 || obs_rts[0] !== 1'b0 || obs_grant[0] !== 5'b00000) begin
      n_fail++; $display("FAIL single_c1 got xbar=%b rts=%b grant=%b exp 00100/0/00000", obs_xbar[0], obs_rts[0], obs_grant[0]);
    end
    step(1'b0, 5'b00100, 1'b1);
    n_checks++;
    if (obs_rts[0] !== 1'b1 || obs_grant[0] !== 5'b00100) begin
      n_fail++; $display("FAIL single_c2 got rts=%b grant=%b exp 1/00100", obs_rts[0], obs_grant[0]);
    end
    step(1'b0, 5'b00000, 1'b1);
    n_checks++;
    if (obs_rts[0] !== 1'b0 || obs_grant[0] !== 5'b00000) begin
      n_fail++; $display("FAIL single_c3 got rts=%b grant=%b exp 0/00000", obs_rts[0], obs_grant[0]);
    end
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
  endtask

  task automatic test_pending_hold();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 5'b00100, 1'b0);
      if (c >= 2) begin
        n_checks++;
        if (obs_xbar[0] !== 5'b00100 || obs_rts[0] !== 1'b1 || obs_grant[0] !== '0) begin
          n_fail++; $display("FAIL pending_wait c%0d got xbar=%b rts=%b grant=%b", c, obs_xbar[0], obs_rts[0], obs_grant[0]);
        end
      end
    end
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 5'b01000, 1'b0);
      n_checks++;
      if (obs_xbar[0] !== 5'b00100 || obs_rts[0] !== 1'b1 || obs_grant[0] !== '0) begin
        n_fail++; $display("FAIL pending_toggle c%0d got xbar=%b rts=%b grant=%b", c, obs_xbar[0], obs_rts[0], obs_grant[0]);
      end
    end
    step(1'b0, 5'b01000, 1'b1);
    n_checks++;
    if (obs_grant[0] !== 5'b00100) begin n_fail++; $display("FAIL pending_release got=%b exp=00100", obs_grant[0]); end
    step(1'b0, 5'b01000, 1'b1);
    n_checks++;
    if (obs_xbar[0] !== 5'b01000 || obs_rts[0] !== 1'b0) begin
      n_fail++; $display("FAIL pending_next_owner got xbar=%b rts=%b exp 01000/0", obs_xbar[0], obs_rts[0]);
    end
  endtask

  task automatic test_rotation();
    int seq[12] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 0, 0};
    logic [NP-1:0] e;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 12; i++) exp_q.push_back(NP'(1) << seq[i]);
    for (int c = 0; c < 28; c++) begin
      step(1'b0, 5'b11111, 1'b1);
      n_checks++;
      if ($countones(obs_grant[0]) > 1) begin n_fail++; $display("FAIL rotation_onehot c%0d got=%b", c, obs_grant[0]); end
      if (obs_grant[0] !== '0 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (obs_grant[0] !== e) begin n_fail++; $display("FAIL rotation_order c%0d got=%b exp=%b", c, obs_grant[0], e); end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rotation_count got_missing=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int ng, last_c;
    ng = 0; last_c = -1;
    do_reset();
    for (int c = 0; c < 40 && ng < 10; c++) begin
      step(1'b0, 5'b00010, 1'b1);
      if (c >= 1) begin
        n_checks++;
        if (obs_xbar[0] !== 5'b00010) begin n_fail++; $display("FAIL b2b_owner c%0d got=%b exp=00010", c, obs_xbar[0]); end
      end
      if (obs_grant[0] !== '0) begin
        n_checks++;
        if (obs_grant[0] !== 5'b00010) begin n_fail++; $display("FAIL b2b_grant c%0d got=%b exp=00010", c, obs_grant[0]); end
        n_checks++;
        if (obs_hc[0] !== 8'(ng % 2)) begin n_fail++; $display("FAIL b2b_hold_cnt grant%0d got=%0d exp=%0d", ng, obs_hc[0], ng % 2); end
        if (last_c >= 0) begin
          n_checks++;
          if (c - last_c != 2) begin n_fail++; $display("FAIL b2b_gap grant%0d got=%0d exp=2", ng, c - last_c); end
        end
        last_c = c;
        ng++;
      end
    end
    n_checks++;
    if (ng != 10) begin n_fail++; $display("FAIL b2b_total got=%0d exp=10", ng); end
  endtask

  task automatic test_reset_abort();
    do_reset();
    step(1'b0, 5'b00100, 1'b0);
    step(1'b0, 5'b00100, 1'b0);
    step(1'b1, 5'b00100, 1'b0);
    n_checks++;
    if (obs_rts[0] !== 1'b1) begin n_fail++; $display("FAIL abort_setup_rts got=%b exp=1", obs_rts[0]); end
    step(1'b0, 5'b00011, 1'b1);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_xbar[k] !== '0 || obs_rts[k] !== 1'b0 || obs_grant[k] !== '0) begin
        n_fail++; $display("FAIL abort_after dut%0d got xbar=%b rts=%b grant=%b exp all 0", k, obs_xbar[k], obs_rts[k], obs_grant[k]);
      end
    end
    step(1'b0, 5'b00011, 1'b1);
    n_checks++;
    if (obs_xbar[0] !== 5'b00001) begin n_fail++; $display("FAIL abort_port0_first got=%b exp=00001", obs_xbar[0]); end
    step(1'b0, 5'b00011, 1'b1);
    n_checks++;
    if (obs_grant[0] !== 5'b00001) begin n_fail++; $display("FAIL abort_port0_grant got=%b exp=00001", obs_grant[0]); end
  endtask

  task automatic test_hold_unlimited();
    int g0, g1;
    g0 = 0; g1 = 0;
    do_reset();
    for (int c = 0; c < 60 && g0 < 20; c++) begin
      step(1'b0, 5'b00011, 1'b1);
      if (obs_grant[1] === 5'b00001) g0++;
      if (obs_grant[1][1] === 1'b1) g1++;
      if (c >= 1) begin
        n_checks++;
        if (obs_xbar[1] !== 5'b00001) begin n_fail++; $display("FAIL unlimited_owner c%0d got=%b exp=00001", c, obs_xbar[1]); end
      end
    end
    n_checks++;
    if (g0 != 20) begin n_fail++; $display("FAIL unlimited_port0_grants got=%0d exp=20", g0); end
    n_checks++;
    if (g1 != 0) begin n_fail++; $display("FAIL unlimited_port1_grants got=%0d exp=0", g1); end
  endtask

  task automatic test_random();
    logic [NP-1:0] rq;
    logic r, d;
    rq = '0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      r = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) < 3) rq = NP'($urandom_range(0, 31));
      d = ($urandom_range(0, 3) != 0);
      step(r, rq, d);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if ($countones(obs_grant[k]) > 1) begin n_fail++; $display("FAIL random_onehot dut%0d c%0d got=%b", k, c, obs_grant[k]); end
      end
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    model_valid = 1'b0;
    hmax[0]     = 2;
    hmax[1]     = 0;
    rst         = 1'b1;
    req         = '0;
    dcts        = 1'b0;
    step(1'b1, '0, 1'b0);
    model_valid = 1'b1;
    test_reset();
    test_single_grant();
    test_pending_hold();
    test_rotation();
    test_back_to_back();
    test_reset_abort();
    test_hold_unlimited();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
